// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, access modes and
// the per-port pending slot.
package mem_arbiter_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } arb_state_e;

    typedef enum logic [2:0] {
        MODE_BYTE   = 3'b000,
        MODE_HALF   = 3'b001,
        MODE_WORD   = 3'b010,
        MODE_BYTE_U = 3'b100,
        MODE_HALF_U = 3'b101
    } mem_mode_e;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [2:0]        mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;

    // Stores only know byte/half/word; loads also have the unsigned variants.
    function automatic logic mode_illegal(input logic [2:0] mode, input logic we);
        if (we)
            return mode[2] || (mode[1:0] == 2'b11);
        return (mode == 3'b011) || (mode == 3'b110) || (mode == 3'b111);
    endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane steering for the slot currently selected by the arbiter: enables,
// store replication, load shift and the alignment/mode fault check.
module lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        mode,
    input  logic              we,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] lane_wdata,
    output logic [DATA_W-1:0] lane_rdata,
    output logic              fault
);

    logic       misaligned;
    logic [4:0] shift;

    always_comb begin
        mem_addr   = {addr[ADDR_W-1:2], 2'b00};
        shift      = {addr[1:0], 3'b000};
        lane_rdata = rdata >> shift;
        be         = 4'b0000;
        lane_wdata = wdata;
        misaligned = 1'b0;
        case (mode[1:0])
            2'b00: begin
                be         = 4'b0001 << addr[1:0];
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                misaligned = addr[0];
            end
            2'b10: begin
                be         = 4'b1111;
                misaligned = (addr[1:0] != 2'b00);
            end
            default: be = 4'b0000;
        endcase
        // Loads always fetch the whole word and shift it down afterwards.
        if (!we)
            be = 4'b1111;
        fault = misaligned || mode_illegal(mode, we);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) arbiter onto one shared memory port, data first,
// with per-port pending slots, lane steering, fault and timeout handling.
//
// state   | meaning
// IDLE    | no access on the memory port; picks next pending slot
// SERVE_D | data slot driven onto mem_*, waiting for mem_ack or timeout
// SERVE_I | fetch slot driven onto mem_*, waiting for mem_ack or timeout
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] imem_address,
    input  logic              imem_enable,
    output logic [DATA_W-1:0] imem_data,
    output logic              imem_wait,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic              dmem_enable,
    input  logic [DATA_W-1:0] dmem_write_data,
    input  logic              dmem_write_enable,
    input  logic [2:0]        dmem_write_mode,
    input  logic              dmem_read_enable,
    input  logic [2:0]        dmem_read_mode,
    output logic [DATA_W-1:0] dmem_read_data,
    output logic              dmem_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              access_fault
);

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    arb_state_e         state, state_nxt;
    slot_t              d_slot, i_slot, cur;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               ack_block;
    logic               sel_d;
    logic               accept_d, accept_i;
    logic               done, done_fault, abort, serve_req;

    logic [ADDR_W-1:0]  lane_addr;
    logic [3:0]         lane_be;
    logic [DATA_W-1:0]  lane_wdata, lane_rdata;
    logic               lane_fault;

    assign accept_d = dmem_enable && (dmem_read_enable || dmem_write_enable) && !dmem_wait;
    assign accept_i = imem_enable && !imem_wait;

    // In IDLE the lane logic already looks at the candidate slot so faults
    // can be retired without ever entering a SERVE state.
    assign sel_d = (state == SERVE_D) || ((state == IDLE) && d_slot.valid);
    assign cur   = sel_d ? d_slot : i_slot;

    lane_align u_lane_align (
        .addr       (cur.addr),
        .wdata      (cur.data),
        .mode       (cur.mode),
        .we         (cur.we),
        .rdata      (mem_rdata),
        .mem_addr   (lane_addr),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .lane_rdata (lane_rdata),
        .fault      (lane_fault)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            ack_block <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            ack_block <= abort;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        done       = 1'b0;
        done_fault = 1'b0;
        abort      = 1'b0;
        serve_req  = 1'b0;
        case (state)
            IDLE: begin
                if (d_slot.valid || i_slot.valid) begin
                    if (lane_fault) begin
                        done       = 1'b1;
                        done_fault = 1'b1;
                    end else begin
                        state_nxt = d_slot.valid ? SERVE_D : SERVE_I;
                        timer_nxt = TIMER_LOAD;
                    end
                end
            end
            SERVE_D, SERVE_I: begin
                if (lane_fault) begin
                    done       = 1'b1;
                    done_fault = 1'b1;
                end else begin
                    serve_req = 1'b1;
                    if (mem_ack && !ack_block) begin
                        done = 1'b1;
                    end else if (timer == '0) begin
                        done       = 1'b1;
                        done_fault = 1'b1;
                        abort      = 1'b1;
                    end else begin
                        timer_nxt = timer - TIMER_W'(1);
                    end
                end
                // Re-arbitrate on the completing edge: only the other port can still be pending.
                if (done) begin
                    if (sel_d ? i_slot.valid : d_slot.valid) begin
                        state_nxt = sel_d ? SERVE_I : SERVE_D;
                        timer_nxt = TIMER_LOAD;
                    end else begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_slot         <= '0;
            i_slot         <= '0;
            dmem_wait      <= 1'b0;
            imem_wait      <= 1'b0;
            dmem_read_data <= '0;
            imem_data      <= '0;
            access_fault   <= 1'b0;
        end else begin
            access_fault <= done_fault;

            if (done && sel_d) begin
                d_slot.valid <= 1'b0;
                dmem_wait    <= 1'b0;
                if (done_fault || !d_slot.we)
                    dmem_read_data <= done_fault ? '0 : lane_rdata;
            end else if (accept_d) begin
                d_slot    <= '{valid: 1'b1,
                               we:    dmem_write_enable,
                               mode:  dmem_write_enable ? dmem_write_mode : dmem_read_mode,
                               addr:  dmem_address,
                               data:  dmem_write_data};
                dmem_wait <= 1'b1;
            end

            if (done && !sel_d) begin
                i_slot.valid <= 1'b0;
                imem_wait    <= 1'b0;
                imem_data    <= done_fault ? '0 : lane_rdata;
            end else if (accept_i) begin
                i_slot    <= '{valid: 1'b1,
                               we:    1'b0,
                               mode:  MODE_WORD,
                               addr:  imem_address,
                               data:  '0};
                imem_wait <= 1'b1;
            end
        end
    end

    // The memory port reads as all-zero whenever no request is out.
    assign mem_req   = serve_req;
    assign mem_addr  = serve_req ? lane_addr : '0;
    assign mem_we    = serve_req && cur.we;
    assign mem_be    = serve_req ? lane_be : 4'b0000;
    assign mem_wdata = serve_req ? lane_wdata : '0;

endmodule
